// File: rtl/btree_mux_seq_if.sv
// Result stream from the sequencer's FIFO toward the colour stage.
// The master drives the head entry; the slave returns ready.
interface btree_mux_seq_if #(
  parameter int INDEX_WIDTH = 6
);
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_hit;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_eol;
  logic                   out_last;

  modport master (
    output out_valid,
    output out_hit,
    output out_index,
    output out_eol,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_hit,
    input  out_index,
    input  out_eol,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/btree_mux_seq.sv
// Raster sequencer for the btree_mux hit-test path: issues pixel coordinates,
// tracks them through the fixed mux latency and buffers results under credit control.
module btree_mux_seq #(
  parameter int RECT_COUNT  = 64,
  parameter int INDEX_WIDTH = $clog2(RECT_COUNT),
  parameter int MUX_LATENCY = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int COORD_WIDTH = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_start,
  input  logic                   abort,
  output logic [COORD_WIDTH-1:0] pix_x,
  output logic [COORD_WIDTH-1:0] pix_y,
  output logic                   pix_issue,
  input  logic                   mux_flag,
  input  logic [INDEX_WIDTH-1:0] mux_index,
  btree_mux_seq_if.master        result,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = INDEX_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [COORD_WIDTH-1:0] x_reg;
  logic [COORD_WIDTH-1:0] y_reg;
  logic                   at_eol;
  logic                   at_last;

  logic [MUX_LATENCY-1:0] tag_valid_reg;
  logic [MUX_LATENCY-1:0] tag_valid_next;
  logic [MUX_LATENCY-1:0] tag_eol_reg;
  logic [MUX_LATENCY-1:0] tag_eol_next;
  logic [MUX_LATENCY-1:0] tag_last_reg;
  logic [MUX_LATENCY-1:0] tag_last_next;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   inflight_reg;
  logic [CNT_W-1:0]   inflight_next;
  logic [CNT_W-1:0]   credit;

  logic push;
  logic pop;
  logic drain_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign at_eol  = (x_reg == COORD_WIDTH'(H_ACTIVE - 1));
  assign at_last = at_eol && (y_reg == COORD_WIDTH'(V_ACTIVE - 1));

  assign pix_x = x_reg;
  assign pix_y = y_reg;

  // A pop frees its slot in the same cycle, so issue never bubbles under full throughput.
  assign push        = tag_valid_reg[MUX_LATENCY-1];
  assign pop         = result.out_valid && result.out_ready;
  assign credit      = CNT_W'(FIFO_DEPTH) + CNT_W'(pop) - count_reg - inflight_reg;
  assign drain_empty = (inflight_reg == '0) && (count_reg == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (frame_start) state_next = RUN;
        RUN:     if (pix_issue && at_last) state_next = DRAIN;
        DRAIN:   if (drain_empty) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // busy drops together with the frame_done pulse although the state is still DRAIN.
  always_comb begin
    pix_issue  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      RUN: begin
        pix_issue = !abort && (credit != '0);
        busy      = 1'b1;
      end
      DRAIN: begin
        frame_done = drain_empty && !abort;
        busy       = !drain_empty;
      end
      default: begin
        pix_issue  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (abort || (state_reg == IDLE && frame_start)) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (pix_issue) begin
      if (at_eol) begin
        x_reg <= '0;
        y_reg <= at_last ? '0 : y_reg + COORD_WIDTH'(1);
      end else begin
        x_reg <= x_reg + COORD_WIDTH'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MUX_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_in
        assign tag_valid_next[gi] = pix_issue;
        assign tag_eol_next[gi]   = at_eol;
        assign tag_last_next[gi]  = at_last;
      end else begin : g_shift
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_eol_next[gi]   = tag_eol_reg[gi-1];
        assign tag_last_next[gi]  = tag_last_reg[gi-1];
      end
    end
  endgenerate

  // Clearing the tags on abort is what discards results still inside the mux.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_valid_reg <= '0;
      tag_eol_reg   <= '0;
      tag_last_reg  <= '0;
    end else if (abort) begin
      tag_valid_reg <= '0;
      tag_eol_reg   <= '0;
      tag_last_reg  <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_eol_reg   <= tag_eol_next;
      tag_last_reg  <= tag_last_next;
    end
  end

  assign push_entry = {mux_flag,
                       mux_flag ? mux_index : {INDEX_WIDTH{1'b0}},
                       tag_eol_reg[MUX_LATENCY-1],
                       tag_last_reg[MUX_LATENCY-1]};

  always_ff @(posedge clk) begin
    if (push && !abort) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  assign count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign inflight_next = inflight_reg + CNT_W'(pix_issue) - CNT_W'(push);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else if (abort) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
    end
  end

  // Head fields are masked by valid so an empty or flushed FIFO presents zeros.
  assign head_entry       = mem[rd_ptr_reg];
  assign result.out_valid = (count_reg != '0);
  assign result.out_hit   = result.out_valid & head_entry[ENTRY_W-1];
  assign result.out_index = result.out_valid ? head_entry[ENTRY_W-2:2] : {INDEX_WIDTH{1'b0}};
  assign result.out_eol   = result.out_valid & head_entry[1];
  assign result.out_last  = result.out_valid & head_entry[0];

endmodule

// File: tb/tb_btree_mux_seq.sv
// Self-checking bench for btree_mux_seq on a 4x2 raster with a 2-cycle mux model.
// A per-cycle vector table covers the basic frame; hand sequences cover stalls, abort and restarts.
module tb_btree_mux_seq;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_start;
  logic       abort;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_issue;
  logic       mux_flag;
  logic [5:0] mux_index;
  logic       busy;
  logic       frame_done;

  btree_mux_seq_if #(.INDEX_WIDTH(6)) bus ();

  btree_mux_seq #(
    .RECT_COUNT (64),
    .INDEX_WIDTH(6),
    .MUX_LATENCY(LAT),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .COORD_WIDTH(10),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_start(frame_start),
    .abort      (abort),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_issue  (pix_issue),
    .mux_flag   (mux_flag),
    .mux_index  (mux_index),
    .result     (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Mux model: fixed two-stage pipeline with no flush, like the real btree_mux.
  logic       flag0_mode = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [9:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;

  always @(posedge clk) begin
    v1 <= v0;
    x1 <= x0;
    y1 <= y0;
    v0 <= pix_issue;
    x0 <= pix_x;
    y0 <= pix_y;
  end

  always_comb begin
    mux_flag  = 1'b1;
    mux_index = 6'h3f;
    if (v1) begin
      if (flag0_mode && x1 == 10'd2 && y1 == 10'd0) begin
        mux_flag  = 1'b0;
        mux_index = 6'd5;
      end else begin
        mux_index = 6'((4 * int'(y1) + int'(x1)) % 64);
      end
    end
  end

  // Scoreboard: expected result pushed at issue, compared at pop.
  typedef struct {
    logic       hit;
    logic [5:0] idx;
    logic       eol;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   ex = 0;
  int   ey = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      sb.delete();
      ex = 0;
      ey = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("pop_with_empty_scoreboard", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_hit", int'(bus.out_hit), int'(e.hit));
          check("out_index", int'(bus.out_index), int'(e.idx));
          check("out_eol", int'(bus.out_eol), int'(e.eol));
          check("out_last", int'(bus.out_last), int'(e.last));
        end
      end
      if (pix_issue) begin
        check("pix_x", int'(pix_x), ex);
        check("pix_y", int'(pix_y), ey);
        e.hit  = !(flag0_mode && ex == 2 && ey == 0);
        e.idx  = e.hit ? 6'((4 * ey + ex) % 64) : 6'd0;
        e.eol  = (ex == H - 1);
        e.last = (ex == H - 1) && (ey == V - 1);
        sb.push_back(e);
        check("occupancy_le_depth", int'(sb.size() <= DEPTH), 1);
        if (ex == H - 1) begin
          ex = 0;
          ey = (ey == V - 1) ? 0 : ey + 1;
        end else begin
          ex = ex + 1;
        end
      end
      if (abort) begin
        sb.delete();
        ex = 0;
        ey = 0;
      end
    end
  end

  typedef struct {
    logic fs;
    logic rdy;
    logic exp_issue;
    logic exp_valid;
    int   exp_idx;
    logic exp_eol;
    logic exp_last;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t tv[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input int budget, output int issues);
    bit done = 0;
    issues = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (pix_issue) issues++;
      if (frame_done) done = 1;
      tick();
    end
    check("frame_done_within_budget", int'(done), 1);
  endtask

  initial begin
    int issues;
    int valid_seen;

    for (int c = 0; c < 14; c++) begin
      tv[c].fs        = (c == 0);
      tv[c].rdy       = 1'b1;
      tv[c].exp_issue = (c >= 1 && c <= 8);
      tv[c].exp_valid = (c >= 4 && c <= 11);
      tv[c].exp_idx   = tv[c].exp_valid ? c - 4 : 0;
      tv[c].exp_eol   = tv[c].exp_valid && ((c - 4) % 4 == 3);
      tv[c].exp_last  = (c == 11);
      tv[c].exp_busy  = (c >= 1 && c <= 11);
      tv[c].exp_done  = (c == 12);
    end

    // Reset values, with frame_start held during reset.
    resetn      = 1'b0;
    frame_start = 1'b1;
    abort       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_pix_y", int'(pix_y), 0);
    check("rst_pix_issue", int'(pix_issue), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_hit", int'(bus.out_hit), 0);
    check("rst_out_index", int'(bus.out_index), 0);
    check("rst_out_eol", int'(bus.out_eol), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    frame_start = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_issue", int'(pix_issue), 0);
    tick();

    // Basic frame, one vector per cycle.
    for (int c = 0; c < 14; c++) begin
      frame_start   = tv[c].fs;
      bus.out_ready = tv[c].rdy;
      @(negedge clk);
      check($sformatf("c%0d_pix_issue", c), int'(pix_issue), int'(tv[c].exp_issue));
      check($sformatf("c%0d_out_valid", c), int'(bus.out_valid), int'(tv[c].exp_valid));
      check($sformatf("c%0d_busy", c), int'(busy), int'(tv[c].exp_busy));
      check($sformatf("c%0d_frame_done", c), int'(frame_done), int'(tv[c].exp_done));
      if (tv[c].exp_valid) begin
        check($sformatf("c%0d_index", c), int'(bus.out_index), tv[c].exp_idx);
        check($sformatf("c%0d_eol", c), int'(bus.out_eol), int'(tv[c].exp_eol));
        check($sformatf("c%0d_last", c), int'(bus.out_last), int'(tv[c].exp_last));
      end
      tick();
    end
    frame_start = 1'b0;

    // Backpressure: four credits, then one issue per pop.
    bus.out_ready = 1'b0;
    frame_start   = 1'b1;
    tick();
    frame_start = 1'b0;
    issues = 0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (pix_issue) issues++;
      if (c == 19) begin
        check("stall_issue_off", int'(pix_issue), 0);
        check("stall_head_valid", int'(bus.out_valid), 1);
        check("stall_head_index", int'(bus.out_index), 0);
      end
      tick();
    end
    check("stall_issue_count", issues, 4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("resume_issue_on_pop", int'(pix_issue), 1);
    tick();
    run_to_done(40, issues);
    check("resume_issue_count", issues, 3);

    // flag=0 for pixel (2,0): hit and index cleared, neighbours intact.
    flag0_mode  = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_to_done(30, issues);
    check("flag0_issue_count", issues, 8);
    flag0_mode = 1'b0;

    // Abort with two pixels in flight.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_issue", int'(pix_issue), 0);
    tick();
    abort = 1'b0;
    valid_seen = 0;
    for (int c = 4; c < 10; c++) begin
      @(negedge clk);
      if (c == 4) check("abort_idle_busy", int'(busy), 0);
      if (bus.out_valid || frame_done) valid_seen++;
      tick();
    end
    check("abort_no_output", valid_seen, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_to_done(30, issues);
    check("after_abort_issue_count", issues, 8);

    // Ignored frame_start during RUN and on the frame_done cycle; back-to-back frame.
    frame_start = 1'b1;
    tick();
    issues = 0;
    for (int c = 1; c < 12; c++) begin
      frame_start = (c == 5);
      @(negedge clk);
      if (pix_issue) issues++;
      tick();
    end
    check("run_fs_ignored_issues", issues, 8);
    frame_start = 1'b1;
    @(negedge clk);
    check("done_cycle_pulse", int'(frame_done), 1);
    check("done_cycle_busy", int'(busy), 0);
    tick();
    @(negedge clk);
    check("done_fs_ignored_busy", int'(busy), 0);
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("b2b_busy", int'(busy), 1);
    check("b2b_first_issue", int'(pix_issue), 1);
    tick();
    run_to_done(30, issues);
    check("b2b_issue_count", issues, 7);

    // Asynchronous reset in the middle of a frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_issue", int'(pix_issue), 0);
    tick();
    resetn = 1'b1;
    tick();

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1);
  end
endmodule
